sand_update_engine: RTL

Per-frame physics engine for the falling-sand grid. On each `start_i` pulse it scans the cell memory bottom-up and moves every sand cell one row down, or diagonally down when the diagonal feature is compiled in. It drives the cell register file's read and write ports directly. It is the producer that feeds the grid memory scanned out by the display path.

---
 rtl/sand_pkg.sv | 18 +
 rtl/grid_scan_counter.sv | 48 ++++
 rtl/sand_update_engine.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sand_pkg.sv
// Shared cell codes and engine state type for the falling-sand update engine.
package sand_pkg;

  localparam int CELL_EMPTY = 0;
  localparam int CELL_SAND  = 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_CUR,
    RD_BELOW,
    RD_DIAG_A,
    RD_DIAG_B,
    WR_DST,
    WR_SRC,
    DONE
  } state_t;

endpackage

// File: rtl/grid_scan_counter.sv
// Column/row scan position for the sand engine: loads to the bottom-but-one
// row, then steps x across each row and y upward until row 0 is finished.
module grid_scan_counter
  import sand_pkg::*;
#(
  parameter int X_WIDTH = 4,
  parameter int Y_WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_step,
  output logic [X_WIDTH-1:0] o_x,
  output logic [Y_WIDTH-1:0] o_y,
  output logic               o_rowDone,
  output logic               o_frameDone
);

  localparam logic [X_WIDTH-1:0] X_MAX   = '1;
  // 2**Y_WIDTH-2: the bottom row has nowhere to fall, so scanning starts above it
  localparam logic [Y_WIDTH-1:0] Y_START = {{(Y_WIDTH-1){1'b1}}, 1'b0};

  logic [X_WIDTH-1:0] r_x;
  logic [Y_WIDTH-1:0] r_y;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_load) begin
      r_x <= '0;
      r_y <= Y_START;
    end else if (i_step) begin
      if (o_rowDone) begin
        r_x <= '0;
        r_y <= r_y - Y_WIDTH'(1);
      end else begin
        r_x <= r_x + X_WIDTH'(1);
      end
    end
  end

  assign o_x         = r_x;
  assign o_y         = r_y;
  assign o_rowDone   = (r_x == X_MAX);
  assign o_frameDone = o_rowDone && (r_y == '0);

endmodule

// File: rtl/sand_update_engine.sv
// Per-frame falling-sand physics: bottom-up scan moving each sand cell down.
// Optional macro SAND_DIAGONAL_EN adds diagonal slides with a per-frame side preference.
module sand_update_engine
  import sand_pkg::*;
#(
  parameter  int X_WIDTH    = 4,
  parameter  int Y_WIDTH    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int ADDR_WIDTH = X_WIDTH + Y_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] read_address_o,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  output logic                  write_en_o,
  output logic [ADDR_WIDTH-1:0] write_address_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic [ADDR_WIDTH:0]   move_count_o
);

  state_t                r_state;
  state_t                w_next;
  state_t                w_advState;
  logic                  w_load;
  logic                  w_step;
  logic [X_WIDTH-1:0]    w_x;
  logic [Y_WIDTH-1:0]    w_y;
  logic [Y_WIDTH-1:0]    w_yBelow;
  logic                  w_rowDone;
  logic                  w_frameDone;
  logic                  w_isSand;
  logic                  w_isEmpty;
  logic [ADDR_WIDTH-1:0] w_readAddr;
  logic [DATA_WIDTH-1:0] r_sandWord;
  logic [ADDR_WIDTH:0]   r_moveCount;
  logic [ADDR_WIDTH:0]   r_moveCountOut;
  logic                  r_writeEn;
  logic [ADDR_WIDTH-1:0] r_writeAddr;
  logic [DATA_WIDTH-1:0] r_writeData;

  grid_scan_counter #(
    .X_WIDTH(X_WIDTH),
    .Y_WIDTH(Y_WIDTH)
  ) u_scan (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_load     (w_load),
    .i_step     (w_step),
    .o_x        (w_x),
    .o_y        (w_y),
    .o_rowDone  (w_rowDone),
    .o_frameDone(w_frameDone)
  );

  assign w_yBelow   = w_y + Y_WIDTH'(1);
  assign w_isSand   = (read_data_i == DATA_WIDTH'(CELL_SAND));
  assign w_isEmpty  = (read_data_i == DATA_WIDTH'(CELL_EMPTY));
  assign w_advState = w_frameDone ? DONE : RD_CUR;

`ifdef SAND_DIAGONAL_EN
  logic               r_preferRight;
  logic [X_WIDTH-1:0] w_xPref;
  logic [X_WIDTH-1:0] w_xOther;
  logic               w_leftOk;
  logic               w_rightOk;
  logic               w_prefOk;
  logic               w_otherOk;

  // Edge columns have no neighbour on one side; such diagonals count as occupied
  assign w_leftOk  = (w_x != '0);
  assign w_rightOk = !w_rowDone;
  assign w_xPref   = r_preferRight ? (w_x + X_WIDTH'(1)) : (w_x - X_WIDTH'(1));
  assign w_xOther  = r_preferRight ? (w_x - X_WIDTH'(1)) : (w_x + X_WIDTH'(1));
  assign w_prefOk  = r_preferRight ? w_rightOk : w_leftOk;
  assign w_otherOk = r_preferRight ? w_leftOk  : w_rightOk;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_preferRight <= 1'b0;
    end else if (r_state == DONE) begin
      r_preferRight <= !r_preferRight;
    end
  end
`else
  logic w_unusedRowDone;
  assign w_unusedRowDone = w_rowDone;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_readAddr = '0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_load = 1'b1;
          w_next = RD_CUR;
        end
      end
      RD_CUR: begin
        w_readAddr = {w_y, w_x};
        if (w_isSand) begin
          w_next = RD_BELOW;
        end else begin
          w_step = 1'b1;
          w_next = w_advState;
        end
      end
      RD_BELOW: begin
        w_readAddr = {w_yBelow, w_x};
        if (w_isEmpty) begin
          w_next = WR_DST;
        end
`ifdef SAND_DIAGONAL_EN
        else if (w_prefOk) begin
          w_next = RD_DIAG_A;
        end else if (w_otherOk) begin
          w_next = RD_DIAG_B;
        end
`endif
        else begin
          w_step = 1'b1;
          w_next = w_advState;
        end
      end
`ifdef SAND_DIAGONAL_EN
      RD_DIAG_A: begin
        w_readAddr = {w_yBelow, w_xPref};
        if (w_isEmpty) begin
          w_next = WR_DST;
        end else if (w_otherOk) begin
          w_next = RD_DIAG_B;
        end else begin
          w_step = 1'b1;
          w_next = w_advState;
        end
      end
      RD_DIAG_B: begin
        w_readAddr = {w_yBelow, w_xOther};
        if (w_isEmpty) begin
          w_next = WR_DST;
        end else begin
          w_step = 1'b1;
          w_next = w_advState;
        end
      end
`endif
      WR_DST: begin
        w_next = WR_SRC;
      end
      WR_SRC: begin
        w_step = 1'b1;
        w_next = w_advState;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // The write port is registered: the destination is captured from the read
  // address that found it empty, so the write lands one cycle later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sandWord     <= '0;
      r_writeEn      <= 1'b0;
      r_writeAddr    <= '0;
      r_writeData    <= '0;
      r_moveCount    <= '0;
      r_moveCountOut <= '0;
    end else begin
      if ((r_state == RD_CUR) && w_isSand) begin
        r_sandWord <= read_data_i;
      end
      r_writeEn <= (w_next == WR_DST) || (w_next == WR_SRC);
      if (w_next == WR_DST) begin
        r_writeAddr <= w_readAddr;
        r_writeData <= r_sandWord;
      end else if (w_next == WR_SRC) begin
        r_writeAddr <= {w_y, w_x};
        r_writeData <= DATA_WIDTH'(CELL_EMPTY);
      end else begin
        r_writeAddr <= '0;
        r_writeData <= '0;
      end
      if (r_state == WR_SRC) begin
        r_moveCount <= r_moveCount + (ADDR_WIDTH+1)'(1);
      end else if (r_state == DONE) begin
        r_moveCountOut <= r_moveCount;
        r_moveCount    <= '0;
      end
    end
  end

  assign busy_o          = (r_state != IDLE);
  assign done_o          = (r_state == DONE);
  assign read_address_o  = w_readAddr;
  assign write_en_o      = r_writeEn;
  assign write_address_o = r_writeAddr;
  assign write_data_o    = r_writeData;
  assign move_count_o    = r_moveCountOut;

endmodule
